// File: rtl/camera_stream_gen_if.sv
// Camera parallel bus as driven by an OV7670 onto the FPGA pins.
// master = camera side (this generator), slave = capture side.
interface camera_stream_gen_if;
    logic       pclk_out;
    logic       vsync_out;
    logic       href_out;
    logic [7:0] pixel_data_out;

    modport master (output pclk_out, vsync_out, href_out, pixel_data_out);
    modport slave  (input  pclk_out, vsync_out, href_out, pixel_data_out);
endinterface

// File: rtl/camera_stream_gen.sv
// Synthetic OV7670-style source: pclk = clk/2, vsync/href framing and
// RGB565 bytes (high byte first) from a latched test pattern.
module camera_stream_gen #(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       enable_in,
    input  logic [1:0]                 mode_in,
    input  logic [15:0]                color_in,
    camera_stream_gen_if.master        cam,
    output logic                       busy_out,
    output logic                       frame_done_out,
    output logic [15:0]                frame_count_out
);
    localparam int LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W      = $clog2(LINE_TICKS);
    localparam int BAR_W      = H_ACTIVE / 8;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [15:0]        line_q, line_d;
    logic [15:0]        k_q, k_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [15:0]        bar_cnt_q, bar_cnt_d;
    logic [15:0]        pix_q, pix_d;
    logic [1:0]         mode_q, mode_d;
    logic [15:0]        color_q, color_d;
    logic               pclk_q, pclk_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [7:0]         data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        count_q, count_d;

    int                 phase_lines;
    logic [2:0]         bi;
    logic [15:0]        bc;
    logic [15:0]        x16;

    function automatic logic [15:0] bar_color(input logic [2:0] i);
        case (i)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        k_d       = k_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        pix_d     = pix_q;
        mode_d    = mode_q;
        color_d   = color_q;
        pclk_d    = ~pclk_q;
        vsync_d   = vsync_q;
        href_d    = href_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        count_d   = count_q;
        bi        = 3'd0;
        bc        = 16'd0;
        x16       = 16'd0;
        case (state_q)
            S_VSYNC:  phase_lines = VSYNC_LINES;
            S_VBACK:  phase_lines = V_BACK;
            S_ACTIVE: phase_lines = V_ACTIVE;
            default:  phase_lines = V_FRONT;
        endcase

        // pclk_q high here means this edge drops pclk: the only edge where the bus may move
        if (pclk_q) begin
            if (state_q == S_IDLE) begin
                if (enable_in) begin
                    state_d = S_VSYNC;
                    col_d   = '0;
                    line_d  = '0;
                    k_d     = '0;
                    mode_d  = mode_in;
                    color_d = color_in;
                end
            end else if (col_q != COL_W'(LINE_TICKS - 1)) begin
                col_d = col_q + COL_W'(1);
            end else begin
                col_d = '0;
                if (line_q != 16'(phase_lines - 1)) begin
                    line_d = line_q + 16'd1;
                end else begin
                    line_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = S_VBACK;
                        S_VBACK:  state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFRONT;
                        default: begin
                            done_d  = 1'b1;
                            count_d = count_q + 16'd1;
                            if (enable_in) begin
                                state_d = S_VSYNC;
                                k_d     = '0;
                                mode_d  = mode_in;
                                color_d = color_in;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end
            end

            vsync_d = (state_d == S_VSYNC);
            href_d  = (state_d == S_ACTIVE) && (col_d < COL_W'(2 * H_ACTIVE));
            busy_d  = (state_d != S_IDLE);
            data_d  = 8'h00;
            if (href_d) begin
                if (!col_d[0]) begin
                    // New pixel: bar counter restarts at the left edge of every line
                    x16 = 16'(col_d >> 1);
                    bi  = (col_d == '0) ? 3'd0  : bar_idx_q;
                    bc  = (col_d == '0) ? 16'd0 : bar_cnt_q;
                    case (mode_q)
                        2'd0:    pix_d = color_q;
                        2'd1:    pix_d = bar_color(bi);
                        2'd2:    pix_d = {x16[4:0], line_d[5:0], x16[4:0]};
                        default: pix_d = k_q;
                    endcase
                    if (bc == 16'(BAR_W - 1)) begin
                        bar_idx_d = bi + 3'd1;
                        bar_cnt_d = 16'd0;
                    end else begin
                        bar_idx_d = bi;
                        bar_cnt_d = bc + 16'd1;
                    end
                    k_d    = k_q + 16'd1;
                    data_d = pix_d[15:8];
                end else begin
                    data_d = pix_q[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            line_q    <= '0;
            k_q       <= '0;
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
            pix_q     <= '0;
            mode_q    <= '0;
            color_q   <= '0;
            pclk_q    <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            line_q    <= line_d;
            k_q       <= k_d;
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            pix_q     <= pix_d;
            mode_q    <= mode_d;
            color_q   <= color_d;
            pclk_q    <= pclk_d;
            vsync_q   <= vsync_d;
            href_q    <= href_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign cam.pclk_out       = pclk_q;
    assign cam.vsync_out      = vsync_q;
    assign cam.href_out       = href_q;
    assign cam.pixel_data_out = data_q;
    assign busy_out           = busy_q;
    assign frame_done_out     = done_q;
    assign frame_count_out    = count_q;
endmodule

// File: tb/tb_camera_stream_gen.sv
// Bench for camera_stream_gen on a shrunk frame geometry: every pclk tick
// is captured and compared against a per-tick model of the frame layout.
module tb_camera_stream_gen;
    localparam int HA = 16, HB = 6, VA = 4, VS = 2, VB = 2, VF = 1;
    localparam int LT = 2 * HA + HB;
    localparam int FT = (VS + VB + VA + VF) * LT;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        enable_in = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [15:0] color_in = 16'd0;
    logic        busy_out, frame_done_out;
    logic [15:0] frame_count_out;

    camera_stream_gen_if cam();

    camera_stream_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
        .mode_in(mode_in), .color_in(color_in), .cam(cam),
        .busy_out(busy_out), .frame_done_out(frame_done_out),
        .frame_count_out(frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0, bad = 0, exp_count = 0, pclk_err = 0;
    logic [9:0]  tick_q[$];
    int          done_at[$];
    bit          busy_seen = 0, prev_ok = 0;
    logic        prev_pclk = 1'b0;

    // One sample per tick, taken mid-way through pclk high
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (prev_ok && cam.pclk_out == prev_pclk) pclk_err++;
            if (cam.pclk_out) tick_q.push_back({cam.vsync_out, cam.href_out, cam.pixel_data_out});
            if (frame_done_out) done_at.push_back(tick_q.size());
            if (busy_out) busy_seen = 1;
        end
        prev_pclk = cam.pclk_out;
        prev_ok   = rst_n_in;
    end

    function automatic logic [9:0] exp_tick(input int t, input logic [1:0] md, input logic [15:0] col);
        int line = t / LT;
        int c = t % LT;
        int x, y;
        logic [15:0] px, xv, yv;
        if (line < VS) return 10'h200;
        if (line < VS + VB || line >= VS + VB + VA || c >= 2 * HA) return 10'h000;
        y = line - VS - VB;
        x = c / 2;
        xv = 16'(x);
        yv = 16'(y);
        case (md)
            2'd0:    px = col;
            2'd1:    px = BARS[x / (HA / 8)];
            2'd2:    px = {xv[4:0], yv[5:0], xv[4:0]};
            default: px = 16'(y * HA + x);
        endcase
        return {2'b01, (c % 2 == 0) ? px[15:8] : px[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic run_frames(input int nfr, input logic [1:0] md, input logic [15:0] col);
        int start, mism, first, idx;
        bit to;
        logic [9:0] got, want;
        tick_q.delete();
        done_at.delete();
        mode_in = md;
        color_in = col;
        enable_in = 1'b1;
        to = 1;
        for (int cyc = 0; cyc < nfr * 2 * FT + 200; cyc++) begin
            // drop enable and disturb the pattern inputs mid-ACTIVE of the last frame
            if (cyc == (nfr - 1) * 2 * FT + 400) begin
                enable_in = 1'b0;
                mode_in = md ^ 2'd1;
                color_in = 16'($urandom);
            end
            if (done_at.size() == nfr) begin to = 0; break; end
            @(posedge clk_in); #1;
        end
        chk("frames_timeout", 32'(to), 32'd0);
        repeat (20) @(posedge clk_in);
        #1;
        start = -1;
        for (int i = 0; i < tick_q.size(); i++)
            if (tick_q[i][9]) begin start = i; break; end
        chk("frame_start_found", 32'(start >= 0), 32'd1);
        if (start < 0) start = 0;
        for (int f = 0; f < nfr; f++) begin
            mism = 0;
            first = -1;
            for (int t = 0; t < FT; t++) begin
                idx = start + f * FT + t;
                got = (idx < tick_q.size()) ? tick_q[idx] : 10'h3FF;
                want = exp_tick(t, md, col);
                if (got !== want) begin
                    mism++;
                    if (first < 0) first = t;
                end
            end
            chk($sformatf("frame%0d_mode%0d_badticks_first%0d", f, md, first), 32'(mism), 32'd0);
            chk($sformatf("frame%0d_done_tick", f),
                32'((f < done_at.size()) ? done_at[f] : -1), 32'(start + (f + 1) * FT));
        end
        chk("done_pulses", 32'(done_at.size()), 32'(nfr));
        idx = start + nfr * FT;
        chk("idle_after_frame", 32'((idx < tick_q.size()) ? tick_q[idx] : 10'h3FF), 32'd0);
        exp_count += nfr;
        chk("frame_count", 32'(frame_count_out), 32'(exp_count));
        chk("busy_after_frame", 32'(busy_out), 32'd0);
    endtask

    initial begin
        int nz;
        bit to;
        repeat (10) @(posedge clk_in);
        #1;
        chk("rst_pclk", 32'(cam.pclk_out), 32'd0);
        chk("rst_vsync", 32'(cam.vsync_out), 32'd0);
        chk("rst_href", 32'(cam.href_out), 32'd0);
        chk("rst_data", 32'(cam.pixel_data_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(frame_done_out), 32'd0);
        chk("rst_count", 32'(frame_count_out), 32'd0);

        rst_n_in = 1'b1;
        busy_seen = 0;
        tick_q.delete();
        repeat (2000) @(posedge clk_in);
        #1;
        nz = 0;
        foreach (tick_q[i]) if (tick_q[i] != 10'h000) nz++;
        chk("idle_activity", 32'(nz), 32'd0);
        chk("idle_ticks", 32'(tick_q.size()), 32'd1000);
        chk("idle_busy_seen", 32'(busy_seen), 32'd0);

        run_frames(1, 2'd0, 16'hF81F);
        run_frames(1, 2'd0, 16'($urandom));
        run_frames(1, 2'd1, 16'($urandom));
        run_frames(1, 2'd2, 16'($urandom));
        run_frames(2, 2'd3, 16'($urandom));

        // reset while href is high
        enable_in = 1'b1;
        mode_in = 2'($urandom_range(0, 3));
        to = 1;
        for (int cyc = 0; cyc < 2 * FT; cyc++) begin
            if (cam.href_out) begin to = 0; break; end
            @(posedge clk_in); #1;
        end
        chk("href_wait_timeout", 32'(to), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("midrst_href", 32'(cam.href_out), 32'd0);
        chk("midrst_vsync", 32'(cam.vsync_out), 32'd0);
        chk("midrst_data", 32'(cam.pixel_data_out), 32'd0);
        chk("midrst_count", 32'(frame_count_out), 32'd0);
        chk("midrst_busy", 32'(busy_out), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        exp_count = 0;
        run_frames(1, 2'd3, 16'($urandom));

        chk("pclk_toggle_errors", 32'(pclk_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
